lsu_ctrl: RTL and testbench

Load/store controller: the initiator that drives the data memory port from the CPU memory stage. Accepts one byte, halfword or word request at a time and turns it into word-wide memory reads and writes. Sub-word stores use read-modify-write; loads return sign- or zero-extended data. The memory read is asynchronous, so `mem_rd` is valid in the same cycle as `mem_adr`.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: size encodings, FSM states
// and the byte-count helper.
package lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WR0,
    WR1,
    RESP
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_bytes = 3'd1;
      SZ_H:    size_bytes = 3'd2;
      SZ_W:    size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane shifter for lsu_ctrl: store merge across a two-word window
// and load byte extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rd0,
  input  logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] wword0,
  output logic [DATA_W-1:0] wword1,
  output logic [DATA_W-1:0] rdata
);

  logic [2*DATA_W-1:0] old;
  logic [2*DATA_W-1:0] shifted;
  logic [2*DATA_W-1:0] bitmask;
  logic [2*DATA_W-1:0] merged;
  logic [2*DATA_W-1:0] ext;
  logic [7:0]          lanes;
  logic [7:0]          bmask;

  always_comb begin
    // {rd1, rd0} is a little-endian 8-byte window starting at the first word
    old     = {rd1, rd0};
    lanes   = (8'd1 << size_bytes(size)) - 8'd1;
    bmask   = lanes << off;
    bitmask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bitmask[i*8 +: 8] = {8{bmask[i]}};
    end
    shifted = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
    merged  = (old & ~bitmask) | (shifted & bitmask);
    wword0  = merged[DATA_W-1:0];
    wword1  = merged[2*DATA_W-1:DATA_W];

    ext = old >> {off, 3'b000};
    case (size)
      SZ_B:    rdata = {{(DATA_W-8){~uns & ext[7]}}, ext[7:0]};
      SZ_H:    rdata = {{(DATA_W-16){~uns & ext[15]}}, ext[15:0]};
      default: rdata = ext[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: word-wide memory access FSM with read-modify-write
// for sub-word stores. Define LSU_MISALIGN_EN to split word-crossing accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_e state, nxt;

  logic              we_r, uns_r, fault_r;
  logic [1:0]        size_r, off_r;
  logic [DATA_W-1:0] wdata_r, rd0_r, rd1;
  logic [ADDR_W-1:0] wa0_r, wa1_r, adr_q;
  logic [DATA_W-1:0] wword0, wword1, ld_data;

  logic              accept;
  logic [1:0]        off_c;
  logic [3:0]        end_c;
  logic              span_c, misal_c, fault_c;
  logic [ADDR_W-1:0] wa0_c;

`ifdef LSU_MISALIGN_EN
  logic              span_r;
  logic [DATA_W-1:0] rd1_r;
  assign rd1 = rd1_r;
`else
  assign rd1 = '0;
`endif

  assign accept  = req_valid && (state == IDLE);
  assign off_c   = req_addr[1:0];
  assign end_c   = {2'b00, off_c} + {1'b0, size_bytes(req_size)};
  assign span_c  = end_c > 4'd4;
  assign misal_c = ((req_size == SZ_H) && req_addr[0]) ||
                   ((req_size == SZ_W) && (off_c != 2'b00));
  assign wa0_c   = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_EN
  assign fault_c = (req_size == 2'b11);
`else
  assign fault_c = (req_size == 2'b11) || misal_c || span_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault_c)                                        nxt = RESP;
          else if (!req_we)                                   nxt = RD0;
          else if ((req_size == SZ_W) && (off_c == 2'b00))    nxt = WR0;
          else                                                nxt = RD0;
        end
      end
      RD0: begin
`ifdef LSU_MISALIGN_EN
        if (span_r)    nxt = RD1;
        else
`endif
        if (we_r)      nxt = WR0;
        else           nxt = RESP;
      end
`ifdef LSU_MISALIGN_EN
      RD1:             nxt = we_r ? WR0 : RESP;
      WR0:             nxt = span_r ? WR1 : RESP;
      WR1:             nxt = RESP;
`else
      WR0:             nxt = RESP;
`endif
      RESP:            nxt = IDLE;
      default:         nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      fault_r <= 1'b0;
      size_r  <= '0;
      off_r   <= '0;
      wdata_r <= '0;
      wa0_r   <= '0;
      wa1_r   <= '0;
      rd0_r   <= '0;
      adr_q   <= '0;
`ifdef LSU_MISALIGN_EN
      span_r  <= 1'b0;
      rd1_r   <= '0;
`endif
    end else begin
      if (accept) begin
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        fault_r <= fault_c;
        size_r  <= req_size;
        off_r   <= off_c;
        wdata_r <= req_wdata;
        wa0_r   <= wa0_c;
        wa1_r   <= wa0_c + ADDR_W'(WORD_BYTES);
`ifdef LSU_MISALIGN_EN
        span_r  <= span_c;
`endif
      end
      if (state == RD0) rd0_r <= mem_rd;
`ifdef LSU_MISALIGN_EN
      if (state == RD1) rd1_r <= mem_rd;
`endif
      // adr_q keeps the last driven address so mem_adr holds between accesses
      if (state inside {RD0, RD1, WR0, WR1}) adr_q <= mem_adr;
    end
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size   (size_r),
    .uns    (uns_r),
    .off    (off_r),
    .wdata  (wdata_r),
    .rd0    (rd0_r),
    .rd1    (rd1),
    .wword0 (wword0),
    .wword1 (wword1),
    .rdata  (ld_data)
  );

  always_comb begin
    case (state)
      RD0, WR0: mem_adr = wa0_r;
      RD1, WR1: mem_adr = wa1_r;
      default:  mem_adr = adr_q;
    endcase
    case (state)
      WR0:     mem_din = wword0;
      WR1:     mem_din = wword1;
      default: mem_din = '0;
    endcase
  end

  assign mem_we     = (state == WR0) || (state == WR1);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_fault = (state == RESP) && fault_r;
  assign resp_rdata = ((state == RESP) && !we_r && !fault_r) ? ld_data : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl with a word-wide async-read memory model;
// expectations follow LSU_MISALIGN_EN when defined.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic [31:0] mem_rd;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [31:0] pre_adr = '0;
  logic [31:0] pre_dat = '0;
  logic [31:0] wl_adr[$];
  logic [31:0] wl_dat[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_we       (mem_we),
    .mem_adr      (mem_adr),
    .mem_din      (mem_din),
    .mem_rd       (mem_rd)
  );

  assign mem_rd = mem[mem_adr[11:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_adr[11:2]] <= pre_dat;
    else if (mem_we) begin
      mem[mem_adr[11:2]] <= mem_din;
      wl_adr.push_back(mem_adr);
      wl_dat.push_back(mem_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] adr, input logic [31:0] dat);
    @(negedge clk);
    pre_we = 1'b1; pre_adr = adr; pre_dat = dat;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_f, input int exp_lat,
                         output logic saw_we, output logic [31:0] first_adr);
    exp_t e;
    int   k;
    sb.push_back('{rdata: exp_rd, fault: exp_f, lat: exp_lat});
    wl_adr.delete();
    wl_dat.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    k = 1;
    saw_we = 1'b0;
    first_adr = mem_adr;
    while (!resp_valid && k < 12) begin
      saw_we |= mem_we;
      @(posedge clk);
      #1;
      k++;
    end
    e = sb.pop_front();
    chk({tag, "_resp"}, 32'(resp_valid), 32'd1);
    chk({tag, "_lat"}, 32'(k), 32'(e.lat));
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_fault"}, 32'(resp_fault), 32'(e.fault));
    chk({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic        sw;
    logic [31:0] fa;
    bit          saw_resp;
    int          n;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", 32'(resp_fault), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_adr", mem_adr, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(32'h100, 32'hDEADBEEF);
    run_req("ldw", 1'b0, 2'b10, 1'b0, 32'h100, '0, 32'hDEADBEEF, 1'b0, 2, sw, fa);
    chk("ldw_adr", fa, 32'h100);
    chk("ldw_nowe", 32'(sw), 32'd0);

    preload(32'h200, 32'h11223344);
    run_req("stb", 1'b1, 2'b00, 1'b0, 32'h203, 32'h000000AA, 32'h0, 1'b0, 3, sw, fa);
    chk("stb_adr", fa, 32'h200);
    chk("stb_nwr", 32'(wl_adr.size()), 32'd1);
    chk("stb_wadr", wl_adr[0], 32'h200);
    chk("stb_wdat", wl_dat[0], 32'hAA223344);

    preload(32'h10, 32'h80FF0000);
    run_req("ldh_s", 1'b0, 2'b01, 1'b0, 32'h12, '0, 32'hFFFF80FF, 1'b0, 2, sw, fa);
    run_req("ldh_u", 1'b0, 2'b01, 1'b1, 32'h12, '0, 32'h000080FF, 1'b0, 2, sw, fa);
    run_req("ldb_s", 1'b0, 2'b00, 1'b0, 32'h13, '0, 32'hFFFFFF80, 1'b0, 2, sw, fa);

    run_req("illegal", 1'b0, 2'b11, 1'b0, 32'h100, '0, 32'h0, 1'b1, 1, sw, fa);

    run_req("stw", 1'b1, 2'b10, 1'b0, 32'h300, 32'h12345678, 32'h0, 1'b0, 2, sw, fa);
    chk("stw_nwr", 32'(wl_adr.size()), 32'd1);
    chk("stw_wadr", wl_adr[0], 32'h300);
    chk("stw_wdat", wl_dat[0], 32'h12345678);

    preload(32'h1FC, 32'h33440000);
    preload(32'h200, 32'h00001122);
    preload(32'hFFFFFFFC, 32'h11112222);
    preload(32'h0, 32'h33334444);
`ifdef LSU_MISALIGN_EN
    run_req("ldh_mis", 1'b0, 2'b01, 1'b0, 32'h101, '0, 32'hFFFFADBE, 1'b0, 2, sw, fa);
    run_req("ldw_span", 1'b0, 2'b10, 1'b0, 32'h1FE, '0, 32'h11223344, 1'b0, 3, sw, fa);
    chk("ldw_span_adr", fa, 32'h1FC);
    run_req("stw_span", 1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hCAFEBABE, 32'h0, 1'b0, 5, sw, fa);
    chk("stw_span_nwr", 32'(wl_adr.size()), 32'd2);
    chk("stw_span_wadr0", wl_adr[0], 32'hFFFFFFFC);
    chk("stw_span_wdat0", wl_dat[0], 32'hBABE2222);
    chk("stw_span_wadr1", wl_adr[1], 32'h00000000);
    chk("stw_span_wdat1", wl_dat[1], 32'h3333CAFE);
`else
    run_req("ldh_mis", 1'b0, 2'b01, 1'b0, 32'h101, '0, 32'h0, 1'b1, 1, sw, fa);
    run_req("ldw_span", 1'b0, 2'b10, 1'b0, 32'h1FE, '0, 32'h0, 1'b1, 1, sw, fa);
    run_req("stw_span", 1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hCAFEBABE, 32'h0, 1'b1, 1, sw, fa);
    chk("stw_span_nwr", 32'(wl_adr.size()), 32'd0);
`endif

    // Abort a sub-word store in its WR0 cycle
    wl_adr.delete();
    wl_dat.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h205; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 6) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_wr0", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_adr", mem_adr, 32'd0);
    chk("abort_din", mem_din, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      saw_resp |= resp_valid;
    end
    chk("abort_noresp", 32'(saw_resp), 32'd0);
    chk("abort_nowrite", 32'(wl_adr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
